// File: rtl/dram_sched.sv
// dram_sched: round-robin DRAM bus arbiter with quantum preemption,
// atomic-lock hold of ownership and drain of the shared controller between owners.
module dram_sched #(
    parameter int NCORES  = 2,
    parameter int QUANTUM = 10,
    parameter int IDW     = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NCORES-1:0] i_req,
    input  logic [NCORES-1:0] i_lock,
    input  logic              i_dram_busy,
    output logic [IDW-1:0]    o_grant_id,
    output logic              o_grant_valid,
    output logic [NCORES-1:0] o_core_busy,
    output logic [15:0]       o_switch_cnt
);
    localparam int LW = $clog2(NCORES);
    localparam int CW = $clog2(QUANTUM);

    typedef enum logic [1:0] {IDLE, SWITCH, RUN, DRAIN} state_t;

    state_t         r_state, w_nxt;
    logic [IDW-1:0] r_gid, w_pick;
    logic [CW-1:0]  r_cnt;
    logic [15:0]    r_sw;
    logic [LW-1:0]  w_own, w_idx;
    logic           w_req_own, w_lock_own, w_other, w_qdone;

    assign w_own      = r_gid[LW-1:0];
    assign w_req_own  = i_req[w_own];
    assign w_lock_own = i_lock[w_own];
    assign w_other    = |(i_req & ~(NCORES'(1) << w_own));
    assign w_qdone    = r_cnt == CW'(QUANTUM - 1);

    // Scan from farthest to nearest so the nearest requester after the owner wins;
    // the index wraps naturally because NCORES is a power of two.
    always_comb begin
        w_pick = r_gid;
        w_idx  = '0;
        for (int k = NCORES; k >= 1; k--) begin
            w_idx = w_own + LW'(k);
            if (i_req[w_idx]) w_pick = IDW'(w_idx);
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    w_nxt = |i_req ? SWITCH : IDLE;
            SWITCH:  w_nxt = RUN;
            RUN:     w_nxt = (!w_lock_own && (w_qdone || !w_req_own)) ? DRAIN : RUN;
            DRAIN:   w_nxt = i_dram_busy ? DRAIN : w_other ? SWITCH : w_req_own ? RUN : IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    assign o_grant_valid = r_state == RUN;
    assign o_grant_id    = r_gid;
    assign o_switch_cnt  = r_sw;

    always_comb begin
        o_core_busy        = '1;
        o_core_busy[w_own] = !o_grant_valid || i_dram_busy;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_gid   <= IDW'(NCORES - 1);
            r_cnt   <= '0;
            r_sw    <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (r_state == RUN && w_nxt == RUN) ? (w_qdone ? r_cnt : r_cnt + 1'b1) : '0;
            if (w_nxt == SWITCH) begin
                r_gid <= w_pick;
                r_sw  <= r_sw + {15'd0, r_sw != 16'hFFFF};
            end
        end
    end
endmodule

// File: tb/tb_dram_sched.sv
// tb_dram_sched: table-driven directed checks on a 2-core instance, plus a 4-core
// instance exercised by directed and random stimulus against a behavioural model.
module tb_dram_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, busy2, gv2;
    logic [1:0]  req2, lock2, cb2;
    logic [2:0]  gid2;
    logic [15:0] sc2;

    logic        rst4, busy4, gv4;
    logic [3:0]  req4, lock4, cb4;
    logic [2:0]  gid4;
    logic [15:0] sc4;

    int n_vec = 0;
    int n_bad = 0;

    dram_sched u_dut2 (
        .i_clk(clk), .i_rst(rst2), .i_req(req2), .i_lock(lock2), .i_dram_busy(busy2),
        .o_grant_id(gid2), .o_grant_valid(gv2), .o_core_busy(cb2), .o_switch_cnt(sc2)
    );

    dram_sched #(.NCORES(4), .QUANTUM(10), .IDW(3)) u_dut4 (
        .i_clk(clk), .i_rst(rst4), .i_req(req4), .i_lock(lock4), .i_dram_busy(busy4),
        .o_grant_id(gid4), .o_grant_valid(gv4), .o_core_busy(cb4), .o_switch_cnt(sc4)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  lock;
        logic        busy;
        int          reps;
        logic [2:0]  gid;
        logic        gv;
        logic [1:0]  cb;
        logic [15:0] sc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(logic r, logic [1:0] q, logic [1:0] l, logic b, int n,
                       logic [2:0] g, logic v, logic [1:0] c, logic [15:0] s);
        vec_t e;
        e.rst = r; e.req = q; e.lock = l; e.busy = b; e.reps = n;
        e.gid = g; e.gv = v; e.cb = c; e.sc = s;
        tbl.push_back(e);
    endtask

    // Behavioural model of the 4-core instance: phase 0 idle, 1 switching, 2 owning, 3 draining.
    localparam int N4 = 4;
    localparam int Q  = 10;
    int m_owner, m_phase, m_runs, m_sw;

    function automatic int pick4(int own, logic [3:0] r);
        for (int k = 1; k <= N4; k++)
            if (r[(own + k) % N4]) return (own + k) % N4;
        return own;
    endfunction

    task automatic model_reset();
        m_owner = N4 - 1; m_phase = 0; m_runs = 0; m_sw = 0;
    endtask

    task automatic model_switch(logic [3:0] r);
        m_owner = pick4(m_owner, r);
        m_sw    = (m_sw < 65535) ? m_sw + 1 : m_sw;
        m_phase = 1;
    endtask

    task automatic model_step(logic [3:0] r, logic [3:0] l, logic b);
        case (m_phase)
            0: if (r != 0) model_switch(r);
            1: begin m_phase = 2; m_runs = 0; end
            2: begin
                m_runs++;
                if (!l[m_owner] && (m_runs >= Q || !r[m_owner])) m_phase = 3;
            end
            default: if (!b) begin
                if ((r & ~(4'b0001 << m_owner)) != 0) model_switch(r);
                else if (r[m_owner]) begin m_phase = 2; m_runs = 0; end
                else m_phase = 0;
            end
        endcase
    endtask

    task automatic step4(string nm);
        logic       egv;
        logic [3:0] ecb;
        if (rst4) model_reset();
        #1;
        egv = (m_phase == 2);
        ecb = 4'hF;
        ecb[m_owner] = !egv || busy4;
        n_vec++;
        if (gid4 !== 3'(m_owner) || gv4 !== egv || cb4 !== ecb || sc4 !== 16'(m_sw)) begin
            n_bad++;
            $display("FAIL %s @%0t: got gid=%0d gv=%0b cb=%b sc=%0d, want gid=%0d gv=%0b cb=%b sc=%0d",
                     nm, $time, gid4, gv4, cb4, sc4, m_owner, egv, ecb, m_sw);
        end
        @(posedge clk);
        if (!rst4) model_step(req4, lock4, busy4);
        @(negedge clk);
    endtask

    task automatic chk_id(string nm, logic [2:0] act, logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got grant_id=%0d, want %0d", nm, act, exp);
        end
    endtask

    initial begin
        rst2 = 1'b1; req2 = '0; lock2 = '0; busy2 = 1'b0;
        rst4 = 1'b1; req4 = '0; lock4 = '0; busy4 = 1'b0;
        model_reset();

        // rst req lock busy reps | gid gv cb sc
        add(1, 2'b01, 2'b00, 0, 1,  1, 0, 2'b11, 0);   // single requester, re-grant without SWITCH
        add(0, 2'b01, 2'b00, 0, 1,  1, 0, 2'b11, 0);
        add(0, 2'b01, 2'b00, 0, 1,  0, 0, 2'b11, 1);
        add(0, 2'b01, 2'b00, 0, 10, 0, 1, 2'b10, 1);
        add(0, 2'b01, 2'b00, 0, 1,  0, 0, 2'b11, 1);
        add(0, 2'b01, 2'b00, 0, 10, 0, 1, 2'b10, 1);
        add(0, 2'b01, 2'b00, 0, 1,  0, 0, 2'b11, 1);
        add(1, 2'b11, 2'b00, 0, 1,  1, 0, 2'b11, 0);   // both requesting: owners alternate
        add(0, 2'b11, 2'b00, 0, 1,  1, 0, 2'b11, 0);
        add(0, 2'b11, 2'b00, 0, 1,  0, 0, 2'b11, 1);
        add(0, 2'b11, 2'b00, 0, 10, 0, 1, 2'b10, 1);
        add(0, 2'b11, 2'b00, 0, 1,  0, 0, 2'b11, 1);
        add(0, 2'b11, 2'b00, 0, 1,  1, 0, 2'b11, 2);
        add(0, 2'b11, 2'b00, 0, 10, 1, 1, 2'b01, 2);
        add(0, 2'b11, 2'b00, 0, 1,  1, 0, 2'b11, 2);
        add(0, 2'b11, 2'b00, 0, 1,  0, 0, 2'b11, 3);
        add(0, 2'b01, 2'b00, 0, 1,  0, 1, 2'b10, 3);
        add(1, 2'b01, 2'b00, 0, 1,  1, 0, 2'b11, 0);   // async reset mid-RUN
        add(0, 2'b01, 2'b00, 0, 1,  1, 0, 2'b11, 0);
        add(0, 2'b01, 2'b00, 0, 1,  0, 0, 2'b11, 1);
        add(0, 2'b01, 2'b00, 0, 8,  0, 1, 2'b10, 1);
        add(0, 2'b01, 2'b00, 1, 1,  0, 1, 2'b11, 1);
        add(0, 2'b01, 2'b00, 0, 1,  0, 1, 2'b10, 1);
        add(0, 2'b11, 2'b00, 1, 4,  0, 0, 2'b11, 1);   // DRAIN held by busy controller
        add(0, 2'b11, 2'b00, 0, 1,  0, 0, 2'b11, 1);
        add(0, 2'b01, 2'b00, 0, 1,  1, 0, 2'b11, 2);   // req change during SWITCH ignored
        add(0, 2'b01, 2'b00, 0, 1,  1, 1, 2'b01, 2);
        add(0, 2'b01, 2'b00, 0, 1,  1, 0, 2'b11, 2);
        add(0, 2'b11, 2'b10, 0, 1,  0, 0, 2'b11, 3);   // lock extends RUN to 16 cycles
        add(0, 2'b11, 2'b10, 0, 7,  0, 1, 2'b10, 3);
        add(0, 2'b11, 2'b01, 0, 8,  0, 1, 2'b10, 3);
        add(0, 2'b11, 2'b00, 0, 1,  0, 1, 2'b10, 3);
        add(0, 2'b11, 2'b10, 0, 1,  0, 0, 2'b11, 3);
        add(0, 2'b11, 2'b00, 0, 1,  1, 0, 2'b11, 4);
        add(0, 2'b11, 2'b00, 0, 1,  1, 1, 2'b01, 4);
        add(0, 2'b00, 2'b00, 0, 1,  1, 1, 2'b01, 4);   // requests vanish: back to IDLE
        add(0, 2'b00, 2'b00, 0, 1,  1, 0, 2'b11, 4);
        add(0, 2'b00, 2'b00, 0, 2,  1, 0, 2'b11, 4);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                rst2 = tbl[i].rst; req2 = tbl[i].req; lock2 = tbl[i].lock; busy2 = tbl[i].busy;
                #1;
                n_vec++;
                if (gid2 !== tbl[i].gid || gv2 !== tbl[i].gv || cb2 !== tbl[i].cb || sc2 !== tbl[i].sc) begin
                    n_bad++;
                    $display("FAIL vec[%0d] rep %0d: got gid=%0d gv=%0b cb=%b sc=%0d, want gid=%0d gv=%0b cb=%b sc=%0d",
                             i, r, gid2, gv2, cb2, sc2, tbl[i].gid, tbl[i].gv, tbl[i].cb, tbl[i].sc);
                end
                @(negedge clk);
            end
        end

        // 4 cores: owner 1, then req=1010 hands over to 3 and back to 1
        rst4 = 1'b1;
        step4("n4 reset");
        rst4 = 1'b0; req4 = 4'b0010;
        for (int n = 0; n < 10 && !gv4; n++) step4("n4 first grant");
        chk_id("n4 first owner", gid4, 3'd1);
        req4 = 4'b1010;
        for (int n = 0; n < 40 && gid4 == 3'd1; n++) step4("n4 to core3");
        chk_id("n4 second owner", gid4, 3'd3);
        for (int n = 0; n < 40 && gid4 == 3'd3; n++) step4("n4 to core1");
        chk_id("n4 third owner", gid4, 3'd1);

        for (int n = 0; n < 3000; n++) begin
            req4  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) lock4 = 4'($urandom) & 4'($urandom);
            busy4 = ($urandom_range(0, 3) == 0);
            rst4  = ($urandom_range(0, 499) == 0);
            step4("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
